// File: rtl/multibank_pingpong_buffer_if.sv
// Producer (A) / consumer (B) bus of the multibank ping-pong buffer.
// The master side drives addresses, data and handshakes; the buffer is the slave.
interface multibank_pingpong_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned NUM_BANKS  = 2
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned OCC_W  = $clog2(NUM_BANKS + 1);

  logic [ADDR_W-1:0]     a_address;
  logic                  a_write_enable;
  logic [DATA_WIDTH-1:0] a_data_in;
  logic [DATA_WIDTH-1:0] a_data_out;
  logic                  a_commit;
  logic [LEN_W-1:0]      a_commit_length;
  logic                  a_bank_ready;

  logic [ADDR_W-1:0]     b_address;
  logic                  b_write_enable;
  logic [DATA_WIDTH-1:0] b_data_in;
  logic [DATA_WIDTH-1:0] b_data_out;
  logic                  b_bank_valid;
  logic [LEN_W-1:0]      b_length;
  logic                  b_release;

  logic [OCC_W-1:0]      occupancy;
  logic                  overflow_error;
  logic                  underflow_error;
  logic                  clear_errors;

  modport master (
    output a_address, a_write_enable, a_data_in, a_commit, a_commit_length,
    output b_address, b_write_enable, b_data_in, b_release, clear_errors,
    input  a_data_out, a_bank_ready, b_data_out, b_bank_valid, b_length,
    input  occupancy, overflow_error, underflow_error
  );

  modport slave (
    input  a_address, a_write_enable, a_data_in, a_commit, a_commit_length,
    input  b_address, b_write_enable, b_data_in, b_release, clear_errors,
    output a_data_out, a_bank_ready, b_data_out, b_bank_valid, b_length,
    output occupancy, overflow_error, underflow_error
  );
endinterface

// File: rtl/multibank_pingpong_buffer.sv
// Ring of NUM_BANKS buffer banks handed from producer A to consumer B via
// commit/release handshakes, with per-bank lengths and sticky protocol errors.
module multibank_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned NUM_BANKS  = 2
) (
  input logic                        clock,
  input logic                        reset,
  multibank_pingpong_buffer_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BANK_W = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned OCC_W  = $clog2(NUM_BANKS + 1);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned MEM_W  = BANK_W + ADDR_W;
  localparam int unsigned WORDS  = NUM_BANKS * DEPTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [BANK_W-1:0]     a_bank;
  logic [BANK_W-1:0]     b_bank;
  logic [OCC_W-1:0]      occupancy;
  logic [LEN_W-1:0]      len [NUM_BANKS];
  logic                  overflow_error;
  logic                  underflow_error;
  logic [DATA_WIDTH-1:0] a_rd_data;
  logic [DATA_WIDTH-1:0] b_rd_data;

  logic              a_ready_c;
  logic              b_valid_c;
  logic              a_write_ok_c;
  logic              b_write_ok_c;
  logic              commit_ok_c;
  logic              release_ok_c;
  logic [LEN_W-1:0]  commit_len_c;
  logic [MEM_W-1:0]  a_phys_c;
  logic [MEM_W-1:0]  b_phys_c;

  function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] bank);
    return (bank == BANK_W'(NUM_BANKS - 1)) ? '0 : bank + BANK_W'(1);
  endfunction

  // Handshake qualification, all judged on pre-edge state
  always_comb begin
    a_ready_c    = (occupancy < OCC_W'(NUM_BANKS));
    b_valid_c    = (occupancy != '0);
    a_write_ok_c = bus.a_write_enable & a_ready_c;
    b_write_ok_c = bus.b_write_enable & b_valid_c;
    commit_ok_c  = bus.a_commit & a_ready_c;
    release_ok_c = bus.b_release & b_valid_c;
    commit_len_c = (bus.a_commit_length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.a_commit_length;
    a_phys_c     = {a_bank, bus.a_address};
    b_phys_c     = {b_bank, bus.b_address};
  end

  // A and B never own the same bank while both are ungated, so the ports never collide
  always_ff @(posedge clock) begin
    if (a_write_ok_c) mem[a_phys_c] <= bus.a_data_in;
    if (b_write_ok_c) mem[b_phys_c] <= bus.b_data_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_rd_data <= '0;
      b_rd_data <= '0;
    end else begin
      a_rd_data <= mem[a_phys_c];
      b_rd_data <= mem[b_phys_c];
    end
  end

  // Bank ownership ring
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_bank    <= '0;
      b_bank    <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) len[i] <= '0;
    end else begin
      if (commit_ok_c) begin
        len[a_bank] <= commit_len_c;
        a_bank      <= bank_inc(a_bank);
      end
      if (release_ok_c) b_bank <= bank_inc(b_bank);
      case ({commit_ok_c, release_ok_c})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky protocol errors; clear wins over a same-cycle set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else if (bus.clear_errors) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if ((bus.a_write_enable | bus.a_commit) & ~a_ready_c) overflow_error <= 1'b1;
      if ((bus.b_write_enable | bus.b_release) & ~b_valid_c) underflow_error <= 1'b1;
    end
  end

  assign bus.a_data_out      = a_rd_data;
  assign bus.b_data_out      = b_rd_data;
  assign bus.a_bank_ready    = a_ready_c;
  assign bus.b_bank_valid    = b_valid_c;
  assign bus.b_length        = len[b_bank];
  assign bus.occupancy       = occupancy;
  assign bus.overflow_error  = overflow_error;
  assign bus.underflow_error = underflow_error;

endmodule
